// File: rtl/afficheur7s_scan_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyphs (active-high, a..g
// MSB-first), the blank pattern, the digit-count limit and a width helper.
package afficheur7s_scan_pkg;

  localparam int unsigned MaxDigits = 8;

  localparam logic [6:0] SegOff = 7'b0000000;

  localparam logic [6:0] Glyph0 = 7'b1111110;
  localparam logic [6:0] Glyph1 = 7'b0110000;
  localparam logic [6:0] Glyph2 = 7'b1101101;
  localparam logic [6:0] Glyph3 = 7'b1111001;
  localparam logic [6:0] Glyph4 = 7'b0110011;
  localparam logic [6:0] Glyph5 = 7'b1011011;
  localparam logic [6:0] Glyph6 = 7'b1011111;
  localparam logic [6:0] Glyph7 = 7'b1110010;
  localparam logic [6:0] Glyph8 = 7'b1111111;
  localparam logic [6:0] Glyph9 = 7'b1111011;
  localparam logic [6:0] GlyphA = 7'b1110111;
  localparam logic [6:0] GlyphB = 7'b0011111;
  localparam logic [6:0] GlyphC = 7'b1001110;
  localparam logic [6:0] GlyphD = 7'b0111101;
  localparam logic [6:0] GlyphE = 7'b1001111;
  localparam logic [6:0] GlyphF = 7'b1000111;

  // Bits needed to hold 0..value-1; never less than 1 so a single-digit bank still gets a counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/afficheur7s_scan_hex7seg.sv
// Combinational hex nibble to active-high seven-segment glyph (a..g, MSB = a).
module afficheur7s_scan_hex7seg
  import afficheur7s_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SegOff;
    unique case (nibble_i)
      4'h0: glyph_o = Glyph0;
      4'h1: glyph_o = Glyph1;
      4'h2: glyph_o = Glyph2;
      4'h3: glyph_o = Glyph3;
      4'h4: glyph_o = Glyph4;
      4'h5: glyph_o = Glyph5;
      4'h6: glyph_o = Glyph6;
      4'h7: glyph_o = Glyph7;
      4'h8: glyph_o = Glyph8;
      4'h9: glyph_o = Glyph9;
      4'hA: glyph_o = GlyphA;
      4'hB: glyph_o = GlyphB;
      4'hC: glyph_o = GlyphC;
      4'hD: glyph_o = GlyphD;
      4'hE: glyph_o = GlyphE;
      4'hF: glyph_o = GlyphF;
    endcase
  end

endmodule

// File: rtl/afficheur7s_scan.sv
// Time-multiplexed seven-segment bank driver: frame-latched inputs, one digit per slot,
// leading-zero suppression, per-digit blanking, decimal points and inter-slot dead time.
module afficheur7s_scan
  import afficheur7s_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter bit          COMMON_ANODE   = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*N_DIGITS-1:0]   Value,
  input  logic [N_DIGITS-1:0]     Blank,
  input  logic [N_DIGITS-1:0]     DpIn,
  input  logic                    Lzs,
  output logic [0:6]              Seg,
  output logic                    Dp,
  output logic [N_DIGITS-1:0]     Dig,
  output logic                    FrameTick
);

  localparam int unsigned DivW = clog2(CLK_DIV);
  localparam int unsigned IdxW = clog2(N_DIGITS);

  localparam logic [6:0]          SegInv = {7{COMMON_ANODE}};
  localparam logic [N_DIGITS-1:0] DigInv = {N_DIGITS{DIG_ACTIVE_LOW}};

  if (N_DIGITS == 0 || N_DIGITS > MaxDigits) begin : gen_bad_n_digits
    $error("N_DIGITS must be in 1..%0d", MaxDigits);
  end
  if (CLK_DIV < 2 || DEAD_CYCLES >= CLK_DIV) begin : gen_bad_timing
    $error("need CLK_DIV >= 2 and DEAD_CYCLES < CLK_DIV");
  end

  logic [DivW-1:0]       div_q, div_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  start_q;
  logic [4*N_DIGITS-1:0] value_q;
  logic [N_DIGITS-1:0]   blank_q, dpin_q;
  logic                  lzs_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   dig_q;
  logic                  tick_q;

  logic                  div_wrap, idx_wrap, frame_latch, in_dead;
  logic [N_DIGITS-1:0]   supp, dig_on;
  logic                  zero_run, blank_cur, dp_cur, dp_on;
  logic [3:0]            nibble;
  logic [6:0]            glyph, seg_on;

  assign div_wrap    = (div_q == DivW'(CLK_DIV - 1));
  assign idx_wrap    = (idx_q == IdxW'(N_DIGITS - 1));
  // start_q marks the first edge after reset, which latches a frame without advancing the scan.
  assign frame_latch = start_q | (div_wrap & idx_wrap);
  assign in_dead     = (32'(div_q) < DEAD_CYCLES);

  assign div_d = div_wrap ? '0 : div_q + DivW'(1);
  assign idx_d = div_wrap ? (idx_wrap ? '0 : idx_q + IdxW'(1)) : idx_q;

  // A digit is suppressed when it and every more-significant digit are zero; digit 0 never is.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (value_q[i*4 +: 4] == 4'h0);
      supp[i]  = lzs_q & zero_run;
    end
  end

  always_comb begin
    nibble    = 4'h0;
    blank_cur = 1'b0;
    dp_cur    = 1'b0;
    dig_on    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nibble    = value_q[i*4 +: 4];
        blank_cur = blank_q[i] | supp[i];
        dp_cur    = dpin_q[i];
        dig_on[i] = ~in_dead;
      end
    end
  end

  afficheur7s_scan_hex7seg u_hex7seg (
    .nibble_i (nibble),
    .glyph_o  (glyph)
  );

  assign seg_on = (in_dead | blank_cur) ? SegOff : glyph;
  assign dp_on  = ~in_dead & dp_cur;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q   <= '0;
      idx_q   <= '0;
      start_q <= 1'b1;
      value_q <= '0;
      blank_q <= '0;
      dpin_q  <= '0;
      lzs_q   <= 1'b0;
      seg_q   <= SegOff ^ SegInv;
      dp_q    <= COMMON_ANODE;
      dig_q   <= DigInv;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= frame_latch;
      if (frame_latch) begin
        value_q <= Value;
        blank_q <= Blank;
        dpin_q  <= DpIn;
        lzs_q   <= Lzs;
      end
      if (start_q) begin
        start_q <= 1'b0;
        seg_q   <= SegOff ^ SegInv;
        dp_q    <= COMMON_ANODE;
        dig_q   <= DigInv;
      end else begin
        div_q <= div_d;
        idx_q <= idx_d;
        seg_q <= seg_on ^ SegInv;
        dp_q  <= dp_on ^ COMMON_ANODE;
        dig_q <= dig_on ^ DigInv;
      end
    end
  end

  assign Seg       = seg_q;
  assign Dp        = dp_q;
  assign Dig       = dig_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_afficheur7s_scan.sv
// Bench for afficheur7s_scan: a frame/slot model derived from elapsed cycles, checked every
// cycle, plus hand-computed glyph and timing expectations.
module tb_afficheur7s_scan;

  localparam int NDig  = 4;
  localparam int Div   = 8;
  localparam int Dead  = 2;
  localparam int Frame = NDig * Div;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Value = 16'h12AF;
  logic [3:0]  Blank = 4'b0000;
  logic [3:0]  DpIn = 4'b0000;
  logic        Lzs = 1'b0;
  logic [0:6]  Seg;
  logic        Dp;
  logic [3:0]  Dig;
  logic        FrameTick;

  afficheur7s_scan #(
    .N_DIGITS       (NDig),
    .CLK_DIV        (Div),
    .DEAD_CYCLES    (Dead),
    .COMMON_ANODE   (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Value     (Value),
    .Blank     (Blank),
    .DpIn      (DpIn),
    .Lzs       (Lzs),
    .Seg       (Seg),
    .Dp        (Dp),
    .Dig       (Dig),
    .FrameTick (FrameTick)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  // Model state: k counts edges since the first edge after reset release (-1 while in reset).
  int          k = -1;
  logic [15:0] sh_val = '0;
  logic [3:0]  sh_blank = '0;
  logic [3:0]  sh_dp = '0;
  logic        sh_lzs = 1'b0;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  logic [3:0]  exp_dig = 4'hF;
  logic        exp_tick = 1'b0;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111,
    7'b1110010, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101,
    7'b1001111, 7'b1000111
  };

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare at the negedge.
  task automatic step();
    int p, slot, dv;
    logic dead, blk;
    @(posedge Clk);
    if (Reset) begin
      k = -1;
      sh_val = '0; sh_blank = '0; sh_dp = '0; sh_lzs = 1'b0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF; exp_tick = 1'b0;
    end else begin
      k++;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF;
      if (k > 0) begin
        p    = (k - 1) % Frame;
        slot = p / Div;
        dv   = p % Div;
        dead = (dv < Dead);
        blk  = sh_blank[slot] || (sh_lzs && slot > 0 && (sh_val >> (4 * slot)) == 16'h0);
        if (!dead) begin
          exp_dig = ~(4'b0001 << slot);
          exp_dp  = ~sh_dp[slot];
          if (!blk) exp_seg = ~glyph_tab[sh_val[4*slot +: 4]];
        end
      end
      exp_tick = (k % Frame == 0);
      if (exp_tick) begin
        sh_val = Value; sh_blank = Blank; sh_dp = DpIn; sh_lzs = Lzs;
      end
    end
    @(negedge Clk);
    check("cycle", {3'b000, Seg, Dp, Dig, FrameTick},
          {3'b000, exp_seg, exp_dp, exp_dig, exp_tick});
  endtask

  // Advance until the outputs reflect in-frame position target (slot*Div + div_cnt).
  task automatic goto(input int target);
    int n = 0;
    while (k < 1 || ((k - 1) % Frame) != target) begin
      step();
      n++;
      if (n > 3 * Frame) begin
        total++;
        $display("FAIL goto_timeout: position %0d not reached within %0d cycles", target, n);
        return;
      end
    end
  endtask

  task automatic next_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(k >= 0 && k % Frame == 0) && n <= 3 * Frame);
    if (n > 3 * Frame) begin
      total++;
      $display("FAIL frame_timeout: no frame boundary within %0d cycles", n);
    end
  endtask

  initial begin
    int n;
    // Reset state
    step();
    step();
    check("rst_seg", 16'(Seg), 16'h007F);
    check("rst_dig", 16'(Dig), 16'h000F);
    check("rst_dp", 16'(Dp), 16'h0001);
    check("rst_tick", 16'(FrameTick), 16'h0000);
    Reset = 1'b0;
    step();
    check("first_tick", 16'(FrameTick), 16'h0001);
    check("first_dig_off", 16'(Dig), 16'h000F);

    // 12AF, no suppression: slot 0 shows F, slot 3 shows 1, dead time two cycles per slot
    goto(2);
    check("s0_dig", 16'(Dig), 16'(4'b1110));
    check("s0_seg", 16'(Seg), 16'(7'b0111000));
    goto(8);
    check("dead0_dig", 16'(Dig), 16'h000F);
    step();
    check("dead1_dig", 16'(Dig), 16'h000F);
    step();
    check("s1_dig", 16'(Dig), 16'(4'b1101));
    check("s1_seg", 16'(Seg), 16'(7'b0001000));
    goto(26);
    check("s3_dig", 16'(Dig), 16'(4'b0111));
    check("s3_seg", 16'(Seg), 16'(7'b1001111));
    next_frame();
    n = 0;
    do begin
      step();
      n++;
    end while (FrameTick !== 1'b1 && n < 2 * Frame);
    check("tick_period", 16'(n), 16'd32);

    // 0050 with suppression
    Value = 16'h0050; Lzs = 1'b1;
    next_frame();
    goto(2);  check("lzs50_d0", 16'(Seg), 16'(7'b0000001));
    goto(10); check("lzs50_d1", 16'(Seg), 16'(7'b0100100));
    goto(18); check("lzs50_d2", 16'(Seg), 16'h007F);
    goto(26); check("lzs50_d3", 16'(Seg), 16'h007F);

    // 0000 with suppression: only digit 0 lit
    Value = 16'h0000;
    next_frame();
    goto(2);  check("lzs0_d0", 16'(Seg), 16'(7'b0000001));
    goto(10); check("lzs0_d1", 16'(Seg), 16'h007F);
    goto(26); check("lzs0_d3", 16'(Seg), 16'h007F);

    // Mid-frame change is deferred to the next frame
    Value = 16'h1111; Lzs = 1'b0;
    next_frame();
    goto(2);
    check("tear_d0", 16'(Seg), 16'(7'b1001111));
    Value = 16'h2222;
    goto(10); check("tear_d1", 16'(Seg), 16'(7'b1001111));
    goto(26); check("tear_d3", 16'(Seg), 16'(7'b1001111));
    next_frame();
    goto(2);  check("tear_new", 16'(Seg), 16'(7'b0010010));

    // Blanked digit keeps its decimal point
    Value = 16'h1234; Blank = 4'b0010; DpIn = 4'b0010;
    next_frame();
    goto(2);  check("bl_d0_seg", 16'(Seg), 16'(7'b1001100));
    check("bl_d0_dp", 16'(Dp), 16'h0001);
    goto(10); check("bl_d1_seg", 16'(Seg), 16'h007F);
    check("bl_d1_dp", 16'(Dp), 16'h0000);
    check("bl_d1_dig", 16'(Dig), 16'(4'b1101));
    goto(18); check("bl_d2_seg", 16'(Seg), 16'(7'b0010010));
    check("bl_d2_dp", 16'(Dp), 16'h0001);

    // Reset in the middle of slot 2
    Blank = 4'b0000; DpIn = 4'b0000;
    next_frame();
    goto(20);
    Reset = 1'b1;
    step();
    check("mid_rst_dig", 16'(Dig), 16'h000F);
    check("mid_rst_seg", 16'(Seg), 16'h007F);
    check("mid_rst_tick", 16'(FrameTick), 16'h0000);
    Reset = 1'b0;
    step();
    check("mid_rst_tick1", 16'(FrameTick), 16'h0001);
    goto(2);
    check("mid_rst_idx0", 16'(Dig), 16'(4'b1110));
    check("mid_rst_seg0", 16'(Seg), 16'(7'b1001100));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/afficheur7s_scan.md
# afficheur7s_scan

Time-multiplexed driver for a bank of N_DIGITS seven-segment digits that share one segment bus. It latches a packed hexadecimal value once per frame, decodes one digit per scan slot and drives one digit-select line at a time. Optional features are leading-zero suppression, per-digit blanking, decimal points and a dead time between slots. It sits between the datapath (counters, measurement results) and the board display pins, and it supersedes single-digit combinational decoding.

## Interface
Parameters:
- N_DIGITS, 4: number of digits, from 1 to 8.
- CLK_DIV, 50000: Clk cycles per scan slot, at least 2.
- DEAD_CYCLES, 16: cycles at the start of each slot with every digit deselected. Must satisfy 0 ≤ DEAD_CYCLES < CLK_DIV.
- COMMON_ANODE, 1: 1 means Seg and Dp are active-low; 0 means they are active-high.
- DIG_ACTIVE_LOW, 1: 1 means the Dig select lines are active-low.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Value  in  4*N_DIGITS  packed nibbles; Value[3:0] is digit 0, the rightmost digit.
- Blank  in  N_DIGITS  per-digit forced blank; bit i blanks digit i.
- DpIn  in  N_DIGITS  per-digit decimal point request.
- Lzs  in  1  leading-zero suppression enable.
- Seg  out  [0:6]  segments a..g, with Seg[0] = a; the level is set by COMMON_ANODE.
- Dp  out  1  decimal point; the level is set by COMMON_ANODE.
- Dig  out  N_DIGITS  one-hot digit select; the level is set by DIG_ACTIVE_LOW.
- FrameTick  out  1  one-cycle pulse when a new frame latch occurs.

## Operation
- Prescaler `div_cnt` counts from 0 to CLK_DIV-1 and then wraps.
  - Each wrap advances the slot index `idx`, which runs from 0 to N_DIGITS-1 and then wraps to 0.
- Frame latch: when `idx` wraps to 0, or on the first cycle after Reset, sample Value, Blank, DpIn and Lzs into shadow registers.
  - Inputs may change at any time. The display only reflects them at frame boundaries, so no tearing is visible.
- Glyphs use the standard hex set: 0-9, A, b, C, d, E, F.
  - 15 displays "F" (a, e, f, g); it is not blank.
  - Internal encoding is active-high, written MSB-first as a..g: 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110010, 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111.
- Digit i is blank (all segments off) if either condition holds:
  - its shadow Blank bit is set; or
  - shadow Lzs = 1, i > 0, and digits i through N_DIGITS-1 are all zero.
  - Digit 0 is never suppressed by Lzs.
- The Dp request for digit i is honoured even when the digit is blank.
- Output polarity is applied last: invert Seg and Dp if COMMON_ANODE = 1, and invert Dig if DIG_ACTIVE_LOW = 1.

## Timing
- Seg, Dp, Dig and FrameTick are all registered; no output is combinational from any input.
- Reset, sampled on the Clk edge, forces:
  - div_cnt = 0 and idx = 0;
  - shadow registers = 0;
  - Seg and Dp inactive (all 1 if COMMON_ANODE = 1);
  - Dig all inactive;
  - FrameTick = 0.
- First cycle after Reset is deasserted:
  - FrameTick = 1 and the frame latch occurs.
  - Dig stays inactive for DEAD_CYCLES+1 cycles. The extra cycle is the registered-output latency.
- Within a slot, the registered outputs lag div_cnt by one cycle:
  - while div_cnt < DEAD_CYCLES, Dig is all inactive and Seg is inactive;
  - otherwise Dig selects bit idx and Seg/Dp show the glyph for digit idx.
- One full frame lasts N_DIGITS*CLK_DIV cycles, so FrameTick has that period.
- N_DIGITS = 1: idx is constant at 0 and a frame latch occurs every CLK_DIV cycles.
- Reset asserted mid-slot or mid-frame: all state returns to the reset values on that edge. No partial glyph is held.

## Structure
- Shared header afficheur7s_defs.vh holds:
  - the 16 glyph constants;
  - SEG_OFF;
  - the maximum value of N_DIGITS;
  - a clog2 function for the widths of div_cnt and idx.
- Sub-module hex7seg: purely combinational, 4-bit input to 7-bit active-high glyph output, one instance.
- Polarity handling and Lzs evaluation stay in the top level.

## Test plan
- N_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, Value=16'h12AF, Lzs=0:
  - slot 0: Dig = 4'b1110 and Seg = ~1000111;
  - slot 3: Dig = 4'b0111 and Seg = ~0110000;
  - FrameTick period = 32 cycles.
- Value=16'h0050, Lzs=1: digits 3 and 2 blank (Seg = 7'b1111111); digit 1 shows "5"; digit 0 shows "0".
- Value=16'h0000, Lzs=1: only digit 0 is lit and shows "0".
- Change Value mid-frame from 16'h1111 to 16'h2222: the remaining slots still show "1"; "2" appears only after the next FrameTick.
- Blank=4'b0010, DpIn=4'b0010: digit 1 has all segments off and Dp = 0 (active-low); the other digits are unaffected.
- Dead time and reset:
  - check that Dig is all 1 for exactly 2 cycles at the start of each slot;
  - assert Reset for 1 cycle in the middle of slot 2: the next cycle has Dig = 4'b1111, Seg = 7'b1111111 and idx restarts at 0 with FrameTick.
